// File: rtl/dout_return_mux_if.sv
// Bus bundle for dout_return_mux: request tags, per-source data, and the
// registered return-data stage. The design uses the slave view; the requester
// side (processor plus cache/memory controllers) uses the master view.
interface dout_return_mux_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = 2,
   parameter int SRC_W      = 1,
   parameter int CNT_W      = 3
);
   logic                          ReqValid;
   logic [SRC_W-1:0]              ReqSrc;
   logic                          ReqReady;
   logic [NUM_SRC-1:0]            SrcValid;
   logic [NUM_SRC*DATA_WIDTH-1:0] SrcData;
   logic [NUM_SRC-1:0]            SrcReady;
   logic [DATA_WIDTH-1:0]         DataOut;
   logic                          DataValid;
   logic                          DataReady;
   logic [SRC_W-1:0]              DataSrc;
   logic [CNT_W-1:0]              Pending;
   logic                          ErrBadSrc;

   modport slave (
      input  ReqValid, ReqSrc, SrcValid, SrcData, DataReady,
      output ReqReady, SrcReady, DataOut, DataValid, DataSrc, Pending, ErrBadSrc
   );

   modport master (
      output ReqValid, ReqSrc, SrcValid, SrcData, DataReady,
      input  ReqReady, SrcReady, DataOut, DataValid, DataSrc, Pending, ErrBadSrc
   );
endinterface

// File: rtl/dout_return_mux.sv
// In-order read-data return mux. An order FIFO remembers which source answers
// each outstanding request; each source parks one word in a hold register
// until its tag reaches the FIFO head, then the word moves into a registered
// valid/ready output stage. Tags naming a nonexistent source are flagged and
// dropped at the head so the return path never stalls on them.
module dout_return_mux #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SRC    = 2,
   parameter int SRC_W      = 1,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 3
) (
   input logic              clk,
   input logic              rst,
   dout_return_mux_if.slave bus_io
);

   localparam int PTR_W = CNT_W - 1;

   typedef logic [DATA_WIDTH-1:0] data_t;

   // A tag is bad when it names a source index this instance does not have.
   function automatic logic is_bad(input logic [SRC_W-1:0] s);
      return int'(s) >= NUM_SRC;
   endfunction

   // Order FIFO: pointers carry one wrap bit so full and empty are distinct.
   logic [SRC_W-1:0]   tag_q [DEPTH];
   logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;

   // Per-source hold registers.
   logic [NUM_SRC-1:0] hold_vld_q, hold_vld_d;
   data_t              hold_data_q [NUM_SRC];
   data_t              hold_data_d [NUM_SRC];

   // Output stage and sticky error.
   data_t              dout_q, dout_d;
   logic               dvld_q, dvld_d;
   logic [SRC_W-1:0]   dsrc_q, dsrc_d;
   logic               err_q, err_d;

   // Decoded control.
   logic [CNT_W-1:0]   pending;
   logic               fifo_empty;
   logic [SRC_W-1:0]   head_src;
   logic               head_bad;
   logic               head_full;
   data_t              head_data;
   logic               out_free;
   logic               xfer;
   logic               skip;
   logic               req_rdy;
   logic               push;
   logic [NUM_SRC-1:0] src_rdy;

   // Decode FIFO head, hold status and the transfer/skip/handshake conditions.
   always_comb begin
      pending    = wr_ptr_q - rd_ptr_q;
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      head_src   = tag_q[rd_ptr_q[PTR_W-1:0]];
      head_bad   = is_bad(head_src);
      head_full  = 1'b0;
      head_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (int'(head_src) == i) begin
            head_full = hold_vld_q[i];
            head_data = hold_data_q[i];
         end
      end
      out_free = !dvld_q || bus_io.DataReady;
      xfer     = !fifo_empty && !head_bad && head_full && out_free;
      // A bad tag at the head is retired without touching the output stage.
      skip     = !fifo_empty && head_bad;
      // Ready outputs are forced low while reset is asserted.
      req_rdy  = !rst && (pending != CNT_W'(DEPTH));
      push     = bus_io.ReqValid && req_rdy;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_rdy[i] = !rst && (!hold_vld_q[i] || (xfer && int'(head_src) == i));
      end
   end

   // Next-state for pointers, hold registers, output stage and error flag.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
      rd_ptr_d = (xfer || skip) ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
      err_d    = err_q || (push && is_bad(bus_io.ReqSrc));

      hold_vld_d = hold_vld_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         hold_data_d[i] = hold_data_q[i];
         if (xfer && int'(head_src) == i) begin
            hold_vld_d[i] = 1'b0;
         end
         // A capture in the same cycle as the drain refills the register.
         if (bus_io.SrcValid[i] && src_rdy[i]) begin
            hold_vld_d[i]  = 1'b1;
            hold_data_d[i] = bus_io.SrcData[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      dout_d = dout_q;
      dsrc_d = dsrc_q;
      dvld_d = dvld_q;
      if (xfer) begin
         dout_d = head_data;
         dsrc_d = head_src;
         dvld_d = 1'b1;
      end else if (dvld_q && bus_io.DataReady) begin
         dvld_d = 1'b0;
      end
   end

   // State registers; everything clears asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         hold_vld_q <= '0;
         dout_q     <= '0;
         dvld_q     <= 1'b0;
         dsrc_q     <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            hold_data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hold_vld_q <= hold_vld_d;
         dout_q     <= dout_d;
         dvld_q     <= dvld_d;
         dsrc_q     <= dsrc_d;
         err_q      <= err_d;
         if (push) begin
            tag_q[wr_ptr_q[PTR_W-1:0]] <= bus_io.ReqSrc;
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            hold_data_q[i] <= hold_data_d[i];
         end
      end
   end

   assign bus_io.ReqReady  = req_rdy;
   assign bus_io.SrcReady  = src_rdy;
   assign bus_io.DataOut   = dout_q;
   assign bus_io.DataValid = dvld_q;
   assign bus_io.DataSrc   = dsrc_q;
   assign bus_io.Pending   = pending;
   assign bus_io.ErrBadSrc = err_q;

endmodule

// File: doc/dout_return_mux.md
Name: dout_return_mux

Overview:
- Parametrised, registered successor to the single-bit cache/memory data-out select.
- Returns read data to the requester in request-issue order from NUM_SRC sources (source 0 = cache, 1 = memory, further sources = future DDR/prefetch paths).
- Each source has a 1-entry hold register. An order FIFO records which source will answer each outstanding request.
- Output is a registered valid/ready stage. Sits between the cache/memory controllers and the processor load-data path.

Parameters:
DATA_WIDTH  8  width of every data path
NUM_SRC     2  number of data sources (>=2)
SRC_W       1  width of a source index, = clog2(NUM_SRC), minimum 1
DEPTH       4  order-FIFO entries = max outstanding requests (power of 2, >=2)
CNT_W       3  = clog2(DEPTH)+1

Ports:
clk            in   1                     clock; all state on rising edge
rst            in   1                     asynchronous, active-high reset
ReqValid       in   1                     request issued; source tag valid
ReqSrc         in   SRC_W                 source that will return this request's data
ReqReady       out  1                     order FIFO can accept a tag
SrcValid       in   NUM_SRC               per-source data valid
SrcData        in   NUM_SRC*DATA_WIDTH    per-source data; source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
SrcReady       out  NUM_SRC               per-source hold register can accept
DataOut        out  DATA_WIDTH            returned data (registered)
DataValid      out  1                     DataOut valid
DataReady      in   1                     consumer accepts DataOut
DataSrc        out  SRC_W                 source that produced DataOut
Pending        out  CNT_W                 occupied order-FIFO entries
ErrBadSrc      out  1                     sticky: ReqSrc >= NUM_SRC was pushed

Behaviour:
- Reset (async, rst=1): all outputs and internal state go to 0 immediately; FIFO empty; hold registers empty. After release, ReqReady=1 and SrcReady=all-ones from the first cycle.
- Order FIFO: circular, DEPTH entries, read/write pointers carry 1 extra wrap bit.
  - ReqReady = (Pending != DEPTH).
  - Push on ReqValid & ReqReady. A push while full is not possible; ReqValid while full is held off by the requester.
  - Pending updates the cycle after push/pop. Simultaneous push and pop leaves Pending unchanged.
- Bad source: a tag with ReqSrc >= NUM_SRC is still pushed, and ErrBadSrc sets to 1 until reset. When that entry reaches the head it pops with no data transfer and no DataValid, so the pipe does not hang.
- Hold registers, one per source:
  - SrcReady[i] = hold[i] empty OR hold[i] is being transferred this cycle.
  - Capture on SrcValid[i] & SrcReady[i]; all sources capture independently in the same cycle.
- Transfer to output, at a clock edge, when all of these hold:
  - FIFO not empty;
  - hold[head] full;
  - output slot free, i.e. (!DataValid | DataReady).
- On transfer: DataOut<=hold[head], DataSrc<=head, DataValid<=1, FIFO pop, hold[head] cleared. If a capture into the same source occurs in that cycle, the new data is retained.
- Output clear: DataValid clears on DataValid & DataReady with no transfer in that cycle.
- DataOut/DataSrc hold their value while DataValid & !DataReady.
- Data arriving from a source that is not at the FIFO head waits in its hold register; SrcReady[i] stays 0 until that data is drained. Data from a source with no outstanding tag is held indefinitely; the controllers must not send unrequested data.
- Latency: data captured at edge e -> transfer at edge e+1 (if at head and output free) -> DataValid high after e+1. Sustained throughput is 1 word/cycle when the head source's data is already held.
- Ordering: DataOut sequence exactly equals the ReqSrc push order; there is no reordering between sources.

Test Plan:
- Reset in flight: push 3 tags, capture 1 hold, assert rst mid-cycle -> all outputs 0 asynchronously, Pending=0, ReqReady=1, SrcReady=2'b11 after release.
- In-order cache hit: push ReqSrc=0, SrcValid=01 with data 0x5A, DataReady=1 -> DataValid=1 with DataOut=0x5A, DataSrc=0, exactly one cycle; Pending 1->0.
- Out-of-order arrival: push tags 1,0. Cache data 0x11 arrives first, memory 0x22 three cycles later -> output 0x22 then 0x11. SrcReady[0]=0 while 0x11 waits.
- Full FIFO and backpressure:
  - push DEPTH=4 tags -> ReqReady=0, Pending=4;
  - DataReady=0 with output full -> DataOut stable, no pop;
  - raise DataReady -> one pop per cycle, ReqReady returns to 1 after the first pop.
- Simultaneous push/pop at pointer wrap: run 10 alternating-source requests continuously -> Pending never exceeds 4, outputs ordered, pointer wrap is transparent.
- Bad source: with NUM_SRC=3, push ReqSrc=3, then ReqSrc=2 with data 0x7E -> ErrBadSrc=1 stays set, the bad entry is skipped, DataOut=0x7E, DataSrc=2.
